// File: rtl/timer_cmd_sender_if.sv
// Signal bundle between the timer command sender and its host/timer environment.
// The sender uses the master modport; the environment driving it uses slave.
interface timer_cmd_sender_if;
  logic       start;
  logic [3:0] delay_in;
  logic       done;
  logic       data;
  logic       ack;
  logic       busy;
  logic [2:0] state;
  logic [3:0] delay_sent;
  logic       timeout;

  modport master (
    input  start, delay_in, done,
    output data, ack, busy, state, delay_sent, timeout
  );

  modport slave (
    output start, delay_in, done,
    input  data, ack, busy, state, delay_sent, timeout
  );
endinterface

// File: rtl/timer_cmd_sender.sv
// Serial timer-command transmitter: preamble 1101, guard 0, 4-bit delay MSB first, then done/ack.
// Optional done-timeout is enabled by defining SENDER_TIMEOUT_EN.
module timer_cmd_sender #(
  parameter int ACK_CYCLES     = 1,
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_cmd_sender_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    PREAMBLE  = 3'b001,
    GUARD     = 3'b010,
    PAYLOAD   = 3'b011,
    WAIT_DONE = 3'b100,
    ACK       = 3'b101
  } state_t;

  localparam logic [3:0] PREAMBLE_BITS = 4'b1101;

  state_t     state_q, state_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ack_cnt_q, ack_cnt_d;
  logic [3:0] delay_q, delay_d;
  logic       data_q, data_d;
  logic       ack_q, busy_q;

`ifdef SENDER_TIMEOUT_EN
  logic [14:0] to_cnt_q, to_cnt_d;
  logic [14:0] to_limit;
  logic        timeout_q, timeout_d;

  assign to_limit = (15'(delay_q) + 15'd1) * 15'd1000 + 15'(TIMEOUT_MARGIN);
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    ack_cnt_d = ack_cnt_q;
    delay_d   = delay_q;
    data_d    = 1'b0;
`ifdef SENDER_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = PREAMBLE;
          delay_d   = bus.delay_in;
          bit_cnt_d = 2'd0;
        end
      end
      PREAMBLE: begin
        if (bit_cnt_q == 2'd3) begin
          state_d   = GUARD;
          bit_cnt_d = 2'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 2'd1;
        end
      end
      GUARD: begin
        state_d   = PAYLOAD;
        bit_cnt_d = 2'd0;
      end
      PAYLOAD: begin
        if (bit_cnt_q == 2'd3) begin
          state_d   = WAIT_DONE;
          bit_cnt_d = 2'd0;
`ifdef SENDER_TIMEOUT_EN
          to_cnt_d  = 15'd0;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 2'd1;
        end
      end
      WAIT_DONE: begin
        // done beats a simultaneous timeout
        if (bus.done) begin
          state_d   = ACK;
          ack_cnt_d = 3'd0;
        end
`ifdef SENDER_TIMEOUT_EN
        else if (to_cnt_q == to_limit - 15'd1) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 15'd1;
        end
`endif
      end
      ACK: begin
        if (ack_cnt_q == 3'(ACK_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // data is registered from the next state so it lines up with the state output
    case (state_d)
      PREAMBLE: data_d = PREAMBLE_BITS[2'd3 - bit_cnt_d];
      PAYLOAD:  data_d = delay_d[2'd3 - bit_cnt_d];
      default:  data_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 2'd0;
      ack_cnt_q <= 3'd0;
      delay_q   <= 4'd0;
      data_q    <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SENDER_TIMEOUT_EN
      to_cnt_q  <= 15'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      delay_q   <= delay_d;
      data_q    <= data_d;
      ack_q     <= (state_d == ACK);
      busy_q    <= (state_d != IDLE);
`ifdef SENDER_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.data       = data_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;
  assign bus.delay_sent = delay_q;
`ifdef SENDER_TIMEOUT_EN
  assign bus.timeout    = timeout_q;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cmd_sender.sv
// Directed bench for timer_cmd_sender: table of per-cycle vectors plus loopback and timeout sequences.
module tb_timer_cmd_sender;

  localparam int ACK_CYC = 1;
  localparam int TM      = 16;

  logic clk = 1'b0;
  logic reset;

  timer_cmd_sender_if bus ();

  timer_cmd_sender #(.ACK_CYCLES(ACK_CYC), .TIMEOUT_MARGIN(TM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] din;
    logic       done;
    logic       e_data;
    logic       e_ack;
    logic       e_busy;
    logic [2:0] e_state;
    logic [3:0] e_ds;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic start, input logic [3:0] din,
                              input logic done, input logic d, input logic a, input logic b,
                              input logic [2:0] st, input logic [3:0] ds);
    vec_t v;
    v.rst = rst; v.start = start; v.din = din; v.done = done;
    v.e_data = d; v.e_ack = a; v.e_busy = b; v.e_state = st; v.e_ds = ds;
    vecs.push_back(v);
  endfunction

  // Inputs are changed at a falling edge; one rising edge later the outputs are sampled.
  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [10:0] outs();
    return {bus.data, bus.ack, bus.busy, bus.state, bus.delay_sent, bus.timeout};
  endfunction

  initial begin
    int  n;
    bit  found;
    int  bad;
    logic [10:0] exp_o;

    reset = 1'b1; bus.start = 1'b0; bus.delay_in = 4'd0; bus.done = 1'b0;
    step(); step();
    check("reset_state", 32'(outs()), 32'(11'b0));
    reset = 1'b0;

    // Frame 0101 with done/start noise during preamble/guard, then done in WAIT_DONE.
    //   rst st din  done  data ack busy state ds
    add(0, 1, 4'h5, 0,  1, 0, 1, 3'd1, 4'h5);
    add(0, 0, 4'hF, 1,  1, 0, 1, 3'd1, 4'h5);
    add(0, 1, 4'hF, 0,  0, 0, 1, 3'd1, 4'h5);
    add(0, 0, 4'h0, 1,  1, 0, 1, 3'd1, 4'h5);
    add(0, 0, 4'h0, 1,  0, 0, 1, 3'd2, 4'h5);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd3, 4'h5);
    add(0, 0, 4'h0, 0,  1, 0, 1, 3'd3, 4'h5);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd3, 4'h5);
    add(0, 0, 4'h0, 0,  1, 0, 1, 3'd3, 4'h5);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd4, 4'h5);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd4, 4'h5);
    add(0, 0, 4'h0, 1,  0, 1, 1, 3'd5, 4'h5);
    add(0, 0, 4'h0, 0,  0, 0, 0, 3'd0, 4'h5);
    // start and stale done together in IDLE, then reset mid-payload (A = 1010)
    add(0, 1, 4'hA, 1,  1, 0, 1, 3'd1, 4'hA);
    add(0, 0, 4'hA, 1,  1, 0, 1, 3'd1, 4'hA);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd1, 4'hA);
    add(0, 0, 4'h0, 0,  1, 0, 1, 3'd1, 4'hA);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd2, 4'hA);
    add(0, 0, 4'h0, 0,  1, 0, 1, 3'd3, 4'hA);
    add(0, 0, 4'h0, 0,  0, 0, 1, 3'd3, 4'hA);
    add(1, 0, 4'h0, 0,  0, 0, 0, 3'd0, 4'h0);
    // delay=2 frame with start re-pulsed using F; payload stays 0010
    add(0, 1, 4'h2, 0,  1, 0, 1, 3'd1, 4'h2);
    add(0, 0, 4'h2, 0,  1, 0, 1, 3'd1, 4'h2);
    add(0, 1, 4'hF, 0,  0, 0, 1, 3'd1, 4'h2);
    add(0, 0, 4'hF, 0,  1, 0, 1, 3'd1, 4'h2);
    add(0, 0, 4'hF, 0,  0, 0, 1, 3'd2, 4'h2);
    add(0, 0, 4'hF, 0,  0, 0, 1, 3'd3, 4'h2);
    add(0, 0, 4'hF, 0,  0, 0, 1, 3'd3, 4'h2);
    add(0, 0, 4'hF, 0,  1, 0, 1, 3'd3, 4'h2);
    add(0, 0, 4'hF, 0,  0, 0, 1, 3'd3, 4'h2);
    add(0, 0, 4'hF, 0,  0, 0, 1, 3'd4, 4'h2);
    add(0, 0, 4'hF, 1,  0, 1, 1, 3'd5, 4'h2);
    add(0, 0, 4'h0, 0,  0, 0, 0, 3'd0, 4'h2);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; bus.start = vecs[i].start;
      bus.delay_in = vecs[i].din; bus.done = vecs[i].done;
      step();
      exp_o = {vecs[i].e_data, vecs[i].e_ack, vecs[i].e_busy, vecs[i].e_state, vecs[i].e_ds, 1'b0};
      check($sformatf("vec%0d", i), 32'(outs()), 32'(exp_o));
    end
    reset = 1'b0; bus.done = 1'b0;

    // Loopback: delay 0, timer raises done after 1000 WAIT_DONE cycles.
    bus.start = 1'b1; bus.delay_in = 4'd0;
    step();
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.state == 3'd4) found = 1'b1; else step();
    end
    check("loop_reach_wait", 32'(found), 32'd1);
    bad = 0;
    for (int i = 1; i < 1000; i++) begin
      step();
      if (bus.state != 3'd4 || bus.ack || bus.data || bus.timeout) bad++;
    end
    check("loop_wait_quiet", 32'(bad), 32'd0);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("loop_ack", 32'({bus.ack, bus.state, bus.busy}), 32'({1'b1, 3'd5, 1'b1}));
    step();
    check("loop_idle", 32'({bus.ack, bus.state, bus.busy}), 32'({1'b0, 3'd0, 1'b0}));

`ifdef SENDER_TIMEOUT_EN
    // Timeout: delay 0, done held low; expect 1016 WAIT_DONE cycles then a timeout pulse.
    bus.start = 1'b1; bus.delay_in = 4'd0;
    step();
    bus.start = 1'b0;
    n = 0; bad = 0; found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      if (bus.ack) bad++;
      if (bus.timeout) found = 1'b1;
      else if (bus.state == 3'd4) n++;
    end
    check("to_fired", 32'(found), 32'd1);
    check("to_wait_cycles", 32'(n), 32'(1000 + TM));
    check("to_no_ack", 32'(bad), 32'd0);
    check("to_state_idle", 32'({bus.state, bus.busy}), 32'({3'd0, 1'b0}));
    step();
    check("to_pulse_one", 32'(bus.timeout), 32'd0);
`else
    n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_cmd_sender.md
Name: timer_cmd_sender

Overview:
- Transmit end of the serial timer-command protocol.
- Accepts a 4-bit delay code on a start strobe and serialises it as one bit per clock: preamble 1101, one guard bit, then 4 payload bits MSB first.
- Then waits for the timer's done and answers with ack, completing one command transaction.
- Sits between a host/control FSM and the advanced timer's data/done/ack pins.

Parameters:
- ACK_CYCLES, 1, number of cycles ack is held high (1..7).
- TIMEOUT_MARGIN, 16, extra cycles beyond the nominal (delay+1)*1000 before the timeout fires (used only with SENDER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send one command; sampled only in IDLE.
- delay_in  input  4  delay code to send; latched when start is accepted.
- done  input  1  timer done flag; sampled only in WAIT_DONE.
- data  output  1  serial command line, registered.
- ack  output  1  acknowledge to timer, registered.
- busy  output  1  high whenever state != IDLE.
- state  output  3  current FSM state.
- delay_sent  output  4  latched delay code of the current/last command.
- timeout  output  1  one-cycle pulse on done timeout; constant 0 without the macro.

Behaviour:
- Reset values: state=IDLE(000), data=0, ack=0, busy=0, delay_sent=0, timeout=0, bit counter=0, timeout counter=0.
- States: IDLE=000, PREAMBLE=001, GUARD=010, PAYLOAD=011, WAIT_DONE=100, ACK=101; codes 110/111 go to IDLE next cycle.
- IDLE:
  - data=0, ack=0.
  - start=1 at edge T0: latch delay_in into delay_sent and go to PREAMBLE.
- Serial sequence on data, cycles T0+1..T0+9: 1,1,0,1 (PREAMBLE, 4 cycles), 0 (GUARD, 1 cycle), d3,d2,d1,d0 (PAYLOAD, 4 cycles).
  - Bits come from delay_sent, not live delay_in.
  - A 2-bit counter indexes bits inside PREAMBLE/PAYLOAD and clears on each state entry.
- WAIT_DONE: entered at T0+10.
  - data=0 throughout.
  - done sampled high → ACK at the next edge.
- ACK: ack=1 for exactly ACK_CYCLES cycles, then IDLE with ack=0.
- Next start is accepted in the first IDLE cycle; minimum command period = 10 + wait + ACK_CYCLES cycles.
- start while busy=1: ignored, not queued.
- delay_in changes after acceptance: no effect on the frame in flight.
- done high in any state other than WAIT_DONE: ignored.
- done and start both high in IDLE: start accepted; the stale done is ignored until WAIT_DONE.
- reset asserted mid-frame: next edge forces all reset values, data=0 immediately; the partial frame is abandoned. The system resets the timer with the same reset.
- busy is a registered decode of the next state, so it is aligned with state.

Optional Feature:
- Macro: SENDER_TIMEOUT_EN.
- When defined:
  - A 15-bit counter clears on WAIT_DONE entry and increments each WAIT_DONE cycle.
  - If it reaches (delay_sent+1)*1000 + TIMEOUT_MARGIN with done still low: timeout=1 for one cycle and the FSM goes to IDLE without sending ack.
  - done and the limit in the same cycle: done wins (go to ACK, no timeout).
  - Arithmetic is done at 15 bits; maximum limit 16000+TIMEOUT_MARGIN.
- When not defined: no counter logic, timeout tied 0, WAIT_DONE waits indefinitely.

Test Plan:
- delay_in=4'b0101, start pulse at T0 → data over T0+1..T0+9 = 1,1,0,1,0,0,1,0,1; busy=1 from T0+1; state reaches WAIT_DONE at T0+10; data=0 afterwards.
- Loopback with the advanced timer, delay_in=0 → timer counts 1000 cycles, done rises; sender ack=1 for 1 cycle the cycle after done is seen; timer returns to idle; sender returns to IDLE with busy=0.
- start re-pulsed with delay_in=4'hF at T0+3 during a delay=2 frame → payload still 0,0,1,0; delay_sent stays 2.
- done forced high during PREAMBLE and GUARD → no ack; ack occurs only after done is seen in WAIT_DONE.
- reset asserted at T0+7 (mid-PAYLOAD) → next cycle data=0, state=IDLE, busy=0, delay_sent=0; a new start then produces a complete frame.
- With SENDER_TIMEOUT_EN, delay=0, TIMEOUT_MARGIN=16, done held low → timeout pulses after 1016 WAIT_DONE cycles, ack stays 0, state=IDLE.
